// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register of the RV32IM pipelined CPU. It sits directly
//   downstream of the register file. It captures the decoded fields together
//   with the register-file read data, and bypasses MEM- and WB-stage results
//   into the operands. It detects load-use hazards and inserts a bubble for
//   each one, holds its entry while EX is busy, and is killed by a flush.
//
// Parameters
//   XLEN    datapath / operand width
//   CTRL_W  width of the opaque decoded control bundle passed to EX
//   CNT_W   width of the saturating load-use bubble counter
//
// Ports
//   clk_i, rst_ni                      clock (posedge), async active-low reset
//   id_valid_i / id_ready_o            decode-side handshake
//   id_pc_i, id_imm_i, id_ctrl_i       instruction payload
//   id_rs1_i, id_rs2_i, id_rsN_used_i  source indices and use flags
//   id_rd_i, id_wen_i, id_is_load_i    destination and flags
//   rf_rs1_data_i, rf_rs2_data_i       register-file read data
//   mem_wen_i, mem_rd_i, mem_data_i    MEM-stage writeback candidate
//   wb_wen_i, wb_rd_i, wb_data_i       WB-stage register-file write
//   ex_ready_i                         EX accepts the held instruction
//   flush_i                            redirect: kill held and incoming
//   ex_*_o                             registered instruction for EX
//   load_use_stall_o                   a bubble is inserted this cycle
//   lu_stall_cnt_o                     saturating count of load-use bubbles
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              id_valid_i,
    output logic              id_ready_o,
    input  logic [XLEN-1:0]   id_pc_i,
    input  logic [4:0]        id_rs1_i,
    input  logic [4:0]        id_rs2_i,
    input  logic              id_rs1_used_i,
    input  logic              id_rs2_used_i,
    input  logic [4:0]        id_rd_i,
    input  logic              id_wen_i,
    input  logic              id_is_load_i,
    input  logic [XLEN-1:0]   id_imm_i,
    input  logic [CTRL_W-1:0] id_ctrl_i,
    input  logic [XLEN-1:0]   rf_rs1_data_i,
    input  logic [XLEN-1:0]   rf_rs2_data_i,
    input  logic              mem_wen_i,
    input  logic [4:0]        mem_rd_i,
    input  logic [XLEN-1:0]   mem_data_i,
    input  logic              wb_wen_i,
    input  logic [4:0]        wb_rd_i,
    input  logic [XLEN-1:0]   wb_data_i,
    input  logic              ex_ready_i,
    input  logic              flush_i,
    output logic              ex_valid_o,
    output logic [XLEN-1:0]   ex_pc_o,
    output logic [XLEN-1:0]   ex_imm_o,
    output logic [XLEN-1:0]   ex_rs1_data_o,
    output logic [XLEN-1:0]   ex_rs2_data_o,
    output logic [4:0]        ex_rs1_o,
    output logic [4:0]        ex_rs2_o,
    output logic [4:0]        ex_rd_o,
    output logic              ex_wen_o,
    output logic              ex_is_load_o,
    output logic [CTRL_W-1:0] ex_ctrl_o,
    output logic              load_use_stall_o,
    output logic [CNT_W-1:0]  lu_stall_cnt_o
);

    logic              r_valid;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_imm;
    logic [XLEN-1:0]   r_rs1_data;
    logic [XLEN-1:0]   r_rs2_data;
    logic [4:0]        r_rs1;
    logic [4:0]        r_rs2;
    logic [4:0]        r_rd;
    logic              r_wen;
    logic              r_is_load;
    logic [CTRL_W-1:0] r_ctrl;
    logic [CNT_W-1:0]  r_lu_cnt;

    logic              w_hold;
    logic              w_lu_hit;
    logic              w_lu_stall;
    logic [XLEN-1:0]   w_rs1_sel;
    logic [XLEN-1:0]   w_rs2_sel;

    // MEM holds the younger write, so it wins over WB. x0 always reads zero.
    function automatic logic [XLEN-1:0] sel_operand(
        input logic [4:0]      rs,
        input logic [XLEN-1:0] rf_data,
        input logic            m_wen,
        input logic [4:0]      m_rd,
        input logic [XLEN-1:0] m_data,
        input logic            w_wen,
        input logic [4:0]      w_rd,
        input logic [XLEN-1:0] w_data
    );
        if (rs == 5'd0)
            return '0;
        else if (m_wen && (m_rd == rs))
            return m_data;
        else if (w_wen && (w_rd == rs))
            return w_data;
        else
            return rf_data;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    assign w_hold = r_valid & ~ex_ready_i;

    // A load still in EX cannot forward to the next instruction, so a
    // dependent consumer must wait one cycle for the load to reach MEM.
    assign w_lu_hit = (id_rs1_used_i && (id_rs1_i == r_rd)) ||
                      (id_rs2_used_i && (id_rs2_i == r_rd));

    assign w_lu_stall = id_valid_i & r_valid & r_is_load & r_wen &
                        (r_rd != 5'd0) & ~w_hold & ~flush_i & w_lu_hit;

    // Under flush the incoming instruction is consumed and dropped.
    assign id_ready_o = flush_i | (~w_hold & ~w_lu_stall);

    assign w_rs1_sel = sel_operand(id_rs1_i, rf_rs1_data_i, mem_wen_i, mem_rd_i,
                                   mem_data_i, wb_wen_i, wb_rd_i, wb_data_i);
    assign w_rs2_sel = sel_operand(id_rs2_i, rf_rs2_data_i, mem_wen_i, mem_rd_i,
                                   mem_data_i, wb_wen_i, wb_rd_i, wb_data_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_imm      <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_wen      <= 1'b0;
            r_is_load  <= 1'b0;
            r_ctrl     <= '0;
        end else if (flush_i) begin
            r_valid   <= 1'b0;
            r_wen     <= 1'b0;
            r_is_load <= 1'b0;
            r_rd      <= '0;
            r_ctrl    <= '0;
        end else if (w_hold) begin
            // The producer may drain through WB while we wait; keep the
            // operands current so EX sees the final value.
            if (wb_wen_i && (wb_rd_i == r_rs1) && (r_rs1 != 5'd0))
                r_rs1_data <= wb_data_i;
            if (wb_wen_i && (wb_rd_i == r_rs2) && (r_rs2 != 5'd0))
                r_rs2_data <= wb_data_i;
        end else if (w_lu_stall || !id_valid_i) begin
            r_valid   <= 1'b0;
            r_wen     <= 1'b0;
            r_is_load <= 1'b0;
            r_rd      <= '0;
            r_ctrl    <= '0;
        end else begin
            r_valid    <= 1'b1;
            r_pc       <= id_pc_i;
            r_imm      <= id_imm_i;
            r_rs1_data <= w_rs1_sel;
            r_rs2_data <= w_rs2_sel;
            r_rs1      <= id_rs1_i;
            r_rs2      <= id_rs2_i;
            r_rd       <= id_rd_i;
            r_wen      <= id_wen_i;
            r_is_load  <= id_is_load_i;
            r_ctrl     <= id_ctrl_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_lu_cnt <= '0;
        else if (w_lu_stall)
            r_lu_cnt <= sat_inc(r_lu_cnt);
    end

    assign ex_valid_o       = r_valid;
    assign ex_pc_o          = r_pc;
    assign ex_imm_o         = r_imm;
    assign ex_rs1_data_o    = r_rs1_data;
    assign ex_rs2_data_o    = r_rs2_data;
    assign ex_rs1_o         = r_rs1;
    assign ex_rs2_o         = r_rs2;
    assign ex_rd_o          = r_rd;
    assign ex_wen_o         = r_wen;
    assign ex_is_load_o     = r_is_load;
    assign ex_ctrl_o        = r_ctrl;
    assign load_use_stall_o = w_lu_stall;
    assign lu_stall_cnt_o   = r_lu_cnt;

endmodule
